decode_stage: RTL and testbench

Registered, handshaked RV32I/RV64I decode pipeline stage between fetch and register-read. It splits each instruction into its fields, generates the sign-extended immediate for every format, classifies the format and flags illegal encodings. Results go into a two-entry skid buffer with valid/ready flow control on both sides and a flush input. This allows fetch and execute to stall independently without losing or duplicating instructions.

---
 rtl/decode_pkg.sv | 51 +++++
 rtl/decode_fields.sv | 83 ++++++++
 rtl/decode_stage.sv | 134 +++++++++++++
 tb/tb_decode_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types and opcode constants for the decode stage
package decode_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } insn_fmt_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Widest supported PC and data; the stage slices down to its own parameters.
  localparam int MAX_AWIDTH = 64;
  localparam int MAX_XLEN   = 64;

  typedef struct packed {
    logic [MAX_AWIDTH-1:0] pc;
    logic [31:0]           insn;
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [5:0]            shamt;
    logic [MAX_XLEN-1:0]   imm;
    insn_fmt_e             fmt;
    logic                  illegal;
  } decoded_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/decode_fields.sv
// rtl/decode_fields.sv - combinational field split, immediate generation and legality check
module decode_fields
  import decode_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic [31:0]       insn,
  input  logic [AWIDTH-1:0] pc,
  output decoded_t          dec
);

  insn_fmt_e fmt;
  logic      illegal;
  logic      sgn;

  assign sgn = insn[31];

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (insn[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (insn[6:0])
        OPC_LUI, OPC_AUIPC: fmt = FMT_U;
        OPC_JAL:            fmt = FMT_J;
        OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM, OPC_MISC_MEM: fmt = FMT_I;
        OPC_BRANCH:         fmt = FMT_B;
        OPC_STORE:          fmt = FMT_S;
        OPC_OP:             fmt = FMT_R;
        default:            illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    dec         = '0;
    dec.pc      = MAX_AWIDTH'(pc);
    dec.insn    = insn;
    dec.opcode  = insn[6:0];
    dec.rd      = insn[11:7];
    dec.funct3  = insn[14:12];
    dec.rs1     = insn[19:15];
    dec.rs2     = insn[24:20];
    dec.funct7  = insn[31:25];
    dec.shamt   = (DWIDTH == 64) ? insn[25:20] : {1'b0, insn[24:20]};
    dec.fmt     = fmt;
    dec.illegal = illegal;
    // Illegal encodings keep raw register fields; fmt is NONE so imm stays 0.
    case (fmt)
      FMT_I: begin
        dec.rs2    = '0;
        dec.funct7 = '0;
        dec.imm    = {{52{sgn}}, insn[31:20]};
      end
      FMT_S: begin
        dec.rd     = '0;
        dec.funct7 = '0;
        dec.imm    = {{52{sgn}}, insn[31:25], insn[11:7]};
      end
      FMT_B: begin
        dec.rd     = '0;
        dec.funct7 = '0;
        dec.imm    = {{51{sgn}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      end
      FMT_U: begin
        dec.rs1    = '0;
        dec.rs2    = '0;
        dec.funct7 = '0;
        dec.imm    = {{32{sgn}}, insn[31:12], 12'b0};
      end
      FMT_J: begin
        dec.rs1    = '0;
        dec.rs2    = '0;
        dec.funct7 = '0;
        dec.imm    = {{43{sgn}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      end
      default: dec.imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with two-entry skid buffer and flush
module decode_stage
  import decode_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [31:0]               insn_i,
  input  logic [AWIDTH-1:0]         pc_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [AWIDTH-1:0]         pc_o,
  output logic [31:0]               insn_o,
  output logic [6:0]                opcode_o,
  output logic [4:0]                rd_o,
  output logic [4:0]                rs1_o,
  output logic [4:0]                rs2_o,
  output logic [2:0]                funct3_o,
  output logic [6:0]                funct7_o,
  output logic [$clog2(DWIDTH)-1:0] shamt_o,
  output logic [DWIDTH-1:0]         imm_o,
  output logic [2:0]                fmt_o,
  output logic                      illegal_o
);

  decoded_t    in_dec;
  decoded_t    main_q;
  decoded_t    skid_q;
  skid_state_e state_q;
  skid_state_e state_d;
  logic        accept;
  logic        take;
  logic        load_main_in;
  logic        load_main_skid;
  logic        load_skid;

  decode_fields #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_fields (
    .insn (insn_i),
    .pc   (pc_i),
    .dec  (in_dec)
  );

  // Ready depends only on registered state so out_ready_i never reaches fetch combinationally.
  assign in_ready_o  = (state_q != SKID_FULL) & rst;
  assign out_valid_o = (state_q != SKID_EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign take        = out_valid_o & out_ready_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            state_d      = SKID_ONE;
            load_main_in = 1'b1;
          end
        end
        SKID_ONE: begin
          if (accept && take) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = SKID_FULL;
            load_skid = 1'b1;
          end else if (take) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (take) begin
            state_d        = SKID_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_dec;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_dec;
      end
    end
  end

  assign pc_o      = main_q.pc[AWIDTH-1:0];
  assign insn_o    = main_q.insn;
  assign opcode_o  = main_q.opcode;
  assign rd_o      = main_q.rd;
  assign rs1_o     = main_q.rs1;
  assign rs2_o     = main_q.rs2;
  assign funct3_o  = main_q.funct3;
  assign funct7_o  = main_q.funct7;
  assign shamt_o   = main_q.shamt[$clog2(DWIDTH)-1:0];
  assign imm_o     = main_q.imm[DWIDTH-1:0];
  assign fmt_o     = main_q.fmt;
  assign illegal_o = main_q.illegal;

  // Upper bits of the widest-case fields are dropped for narrower configurations.
  logic unused_main_bits;
  assign unused_main_bits = ^{main_q.pc, main_q.imm, main_q.shamt};

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed table-driven bench for decode_stage (RV32 and RV64 instances)
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_pc, a_insn, a_imm;
  logic [6:0]  a_opcode, a_funct7;
  logic [4:0]  a_rd, a_rs1, a_rs2, a_shamt;
  logic [2:0]  a_funct3, a_fmt;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [31:0] b_pc, b_insn;
  logic [63:0] b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [5:0]  b_shamt;
  logic [2:0]  b_funct3, b_fmt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.DWIDTH(32), .AWIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .insn_i(insn), .pc_i(pc), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .pc_o(a_pc), .insn_o(a_insn), .opcode_o(a_opcode), .rd_o(a_rd), .rs1_o(a_rs1),
    .rs2_o(a_rs2), .funct3_o(a_funct3), .funct7_o(a_funct7), .shamt_o(a_shamt),
    .imm_o(a_imm), .fmt_o(a_fmt), .illegal_o(a_illegal)
  );

  decode_stage #(.DWIDTH(64), .AWIDTH(32)) dut64 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .insn_i(insn), .pc_i(pc), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .pc_o(b_pc), .insn_o(b_insn), .opcode_o(b_opcode), .rd_o(b_rd), .rs1_o(b_rs1),
    .rs2_o(b_rs2), .funct3_o(b_funct3), .funct7_o(b_funct7), .shamt_o(b_shamt),
    .imm_o(b_imm), .fmt_o(b_fmt), .illegal_o(b_illegal)
  );

  typedef struct {
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    insn_fmt_e   fmt;
    logic        ill;
    logic [5:0]  sh64;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i_insn, input logic [31:0] i_pc);
    in_valid = 1'b1;
    insn     = i_insn;
    pc       = i_pc;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF10093, 5'd1,  5'd2,  5'd0,  3'd0, 7'h00, 32'hFFFFFFFF, FMT_I,    1'b0, 6'd63};
    vecs[1]  = '{32'h00512423, 5'd0,  5'd2,  5'd5,  3'd2, 7'h00, 32'h00000008, FMT_S,    1'b0, 6'd5};
    vecs[2]  = '{32'hFE000EE3, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFFFFC, FMT_B,    1'b0, 6'd32};
    vecs[3]  = '{32'h123451B7, 5'd3,  5'd0,  5'd0,  3'd5, 7'h00, 32'h12345000, FMT_U,    1'b0, 6'd35};
    vecs[4]  = '{32'h402081B3, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'h00000000, FMT_R,    1'b0, 6'd2};
    vecs[5]  = '{32'hFFFFF06F, 5'd0,  5'd0,  5'd0,  3'd7, 7'h00, 32'hFFFFFFFE, FMT_J,    1'b0, 6'd63};
    vecs[6]  = '{32'h80052283, 5'd5,  5'd10, 5'd0,  3'd2, 7'h00, 32'hFFFFF800, FMT_I,    1'b0, 6'd0};
    vecs[7]  = '{32'h00000000, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, FMT_NONE, 1'b1, 6'd0};
    vecs[8]  = '{32'hFFFFFFFF, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h00000000, FMT_NONE, 1'b1, 6'd63};
    vecs[9]  = '{32'h00000012, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, FMT_NONE, 1'b1, 6'd0};
    vecs[10] = '{32'h02809093, 5'd1,  5'd1,  5'd0,  3'd1, 7'h00, 32'h00000028, FMT_I,    1'b0, 6'd40};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; insn = 32'h00000013; pc = 32'h40; out_ready = 1'b1;
    tick();
    tick();
    check("rst out_valid", 64'(a_out_valid), 64'd0);
    check("rst in_ready", 64'(a_in_ready), 64'd0);
    check("rst insn", 64'(a_insn), 64'd0);
    check("rst fmt", 64'(a_fmt), 64'(FMT_NONE));
    check("rst imm64", b_imm, 64'd0);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("rst release in_ready", 64'(a_in_ready), 64'd1);

    // Back-to-back stream through both widths.
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].insn, 32'h100 + 32'(i) * 4);
      tick();
      check($sformatf("v%0d out_valid", i), 64'(a_out_valid), 64'd1);
      check($sformatf("v%0d in_ready", i), 64'(a_in_ready), 64'd1);
      check($sformatf("v%0d pc", i), 64'(a_pc), 64'(32'h100 + 32'(i) * 4));
      check($sformatf("v%0d insn", i), 64'(a_insn), 64'(vecs[i].insn));
      check($sformatf("v%0d rd", i), 64'(a_rd), 64'(vecs[i].rd));
      check($sformatf("v%0d rs1", i), 64'(a_rs1), 64'(vecs[i].rs1));
      check($sformatf("v%0d rs2", i), 64'(a_rs2), 64'(vecs[i].rs2));
      check($sformatf("v%0d funct3", i), 64'(a_funct3), 64'(vecs[i].f3));
      check($sformatf("v%0d funct7", i), 64'(a_funct7), 64'(vecs[i].f7));
      check($sformatf("v%0d imm32", i), 64'(a_imm), 64'(vecs[i].imm));
      check($sformatf("v%0d imm64", i), b_imm, {{32{vecs[i].imm[31]}}, vecs[i].imm});
      check($sformatf("v%0d fmt", i), 64'(a_fmt), 64'(vecs[i].fmt));
      check($sformatf("v%0d illegal", i), 64'(a_illegal), 64'(vecs[i].ill));
      check($sformatf("v%0d shamt32", i), 64'(a_shamt), 64'(vecs[i].sh64[4:0]));
      check($sformatf("v%0d shamt64", i), 64'(b_shamt), 64'(vecs[i].sh64));
      check($sformatf("v%0d fmt64", i), 64'(b_fmt), 64'(vecs[i].fmt));
    end
    in_valid = 1'b0;
    tick();
    check("drain out_valid", 64'(a_out_valid), 64'd0);

    // Backpressure: third instruction must wait, then all drain in order.
    out_ready = 1'b0;
    send(32'h00100093, 32'h200);
    tick();
    check("bp A insn", 64'(a_insn), 64'h00100093);
    check("bp A in_ready", 64'(a_in_ready), 64'd1);
    send(32'h00200113, 32'h204);
    tick();
    check("bp full in_ready", 64'(a_in_ready), 64'd0);
    check("bp held A", 64'(a_insn), 64'h00100093);
    send(32'h00300193, 32'h208);
    tick();
    check("bp still held A", 64'(a_insn), 64'h00100093);
    check("bp still full", 64'(a_in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp B out", 64'(a_insn), 64'h00200113);
    check("bp B pc", 64'(a_pc), 64'h204);
    check("bp B valid", 64'(a_out_valid), 64'd1);
    tick();
    check("bp C out", 64'(a_insn), 64'h00300193);
    check("bp C rd", 64'(a_rd), 64'd3);
    in_valid = 1'b0;
    tick();
    check("bp drained", 64'(a_out_valid), 64'd0);

    // Flush while FULL with a concurrent instruction offered.
    out_ready = 1'b0;
    send(32'h00400213, 32'h300);
    tick();
    send(32'h00500293, 32'h304);
    tick();
    check("fl full", 64'(a_in_ready), 64'd0);
    send(32'h00600313, 32'h308);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl out_valid", 64'(a_out_valid), 64'd0);
    check("fl in_ready", 64'(a_in_ready), 64'd1);
    tick();
    check("fl no ghost", 64'(a_out_valid), 64'd0);

    // Flush in ONE while an instruction is actually accepted.
    out_ready = 1'b0;
    send(32'h00700393, 32'h400);
    tick();
    send(32'h00800413, 32'h404);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1 out_valid", 64'(a_out_valid), 64'd0);
    tick();
    check("fl1 dropped", 64'(a_out_valid), 64'd0);

    // Reset mid-stream with both entries occupied.
    send(32'h00900493, 32'h500);
    tick();
    send(32'h00A00513, 32'h504);
    tick();
    check("rs full", 64'(a_in_ready), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("rs out_valid", 64'(a_out_valid), 64'd0);
    check("rs in_ready", 64'(a_in_ready), 64'd0);
    check("rs insn", 64'(a_insn), 64'd0);
    check("rs pc", 64'(a_pc), 64'd0);
    check("rs imm", 64'(a_imm), 64'd0);
    check("rs rd", 64'(a_rd), 64'd0);
    check("rs fmt", 64'(a_fmt), 64'(FMT_NONE));
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rs release in_ready", 64'(a_in_ready), 64'd1);
    tick();
    check("rs no pulse", 64'(a_out_valid), 64'd0);
    check("rs64 no pulse", 64'(b_out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
